// File: rtl/id_branch_predict_resolve_pkg.sv
// Shared branch-op and BHT counter encodings for the ID-stage branch unit.
package id_branch_predict_resolve_pkg;

    localparam logic [2:0] BR_BEQ  = 3'b000;
    localparam logic [2:0] BR_BNE  = 3'b001;
    localparam logic [2:0] BR_BLEZ = 3'b010;
    localparam logic [2:0] BR_BGTZ = 3'b011;
    localparam logic [2:0] BR_BLTZ = 3'b100;
    localparam logic [2:0] BR_BGEZ = 3'b101;
    localparam logic [2:0] BR_J    = 3'b110;
    localparam logic [2:0] BR_RSVD = 3'b111;

    localparam logic [1:0] BHT_SNT = 2'b00;
    localparam logic [1:0] BHT_WNT = 2'b01;
    localparam logic [1:0] BHT_WT  = 2'b10;
    localparam logic [1:0] BHT_ST  = 2'b11;

    // Saturating 2-bit counter step toward the resolved direction.
    function automatic logic [1:0] bht_next(input logic [1:0] ctr, input logic taken);
        if (taken)
            return (ctr == BHT_ST) ? BHT_ST : ctr + 2'd1;
        else
            return (ctr == BHT_SNT) ? BHT_SNT : ctr - 2'd1;
    endfunction

endpackage

// File: rtl/branch_bht.sv
// Branch history table: array of 2-bit saturating counters with one
// combinational lookup port and one clocked training port.
module branch_bht
    import id_branch_predict_resolve_pkg::*;
#(
    parameter int DEPTH = 64,
    parameter int IDX_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [IDX_W-1:0] rd_idx,
    output logic             rd_taken,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic             wr_taken
);

    logic [1:0] ctr [DEPTH];

    // NOTE: the table is built from flops, so every entry can be reset
    // asynchronously; a RAM-based table would need a clear sequence instead.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++)
                ctr[i] <= BHT_WNT;
        end else if (wr_en) begin
            // NOTE: non-blocking, so a same-cycle lookup still sees the old counter.
            ctr[wr_idx] <= bht_next(ctr[wr_idx], wr_taken);
        end
    end

    assign rd_taken = ctr[rd_idx][1];

endmodule

// File: rtl/id_branch_predict_resolve.sv
// ID-stage branch resolve with 2-bit BHT prediction and redirect.
// Optional BRANCH_STATS_EN adds saturating branch/mispredict counters.
module id_branch_predict_resolve
    import id_branch_predict_resolve_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int PC_W      = 32,
    parameter int BHT_DEPTH = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [PC_W-1:0]   IF_PC,
    output logic              Predict_Taken_IF,
    input  logic              Branch_ID,
    input  logic              Stall_ID,
    input  logic [2:0]        Branch_Op_ID,
    input  logic              Pred_Taken_ID,
    input  logic [PC_W-1:0]   PC_ID,
    input  logic [PC_W-1:0]   Target_ID,
    input  logic [DATA_W-1:0] Read_data1_ID,
    input  logic [DATA_W-1:0] Read_data2_ID,
    output logic              PCSrc_ID,
    output logic              Mispredict_ID,
    output logic [PC_W-1:0]   Redirect_PC_ID,
    output logic              Flush_IF
`ifdef BRANCH_STATS_EN
    ,
    output logic [31:0]       Branch_Count,
    output logic [31:0]       Mispredict_Count
`endif
);

    localparam int IDX_W = $clog2(BHT_DEPTH);

    logic              resolve_en;
    logic              cond_met;
    logic              taken;
    logic              train_en;
    logic [PC_W-1:0]   pc_plus4;
    logic signed [DATA_W-1:0] a_s;
    logic              idx_unused;

    assign resolve_en = Branch_ID & ~Stall_ID;
    assign a_s        = $signed(Read_data1_ID);
    assign pc_plus4   = PC_ID + PC_W'(4);

    // NOTE: cond_met gets a default before the case so no latch is inferred.
    always_comb begin
        cond_met = 1'b0;
        case (Branch_Op_ID)
            BR_BEQ:  cond_met = (Read_data1_ID == Read_data2_ID);
            BR_BNE:  cond_met = (Read_data1_ID != Read_data2_ID);
            BR_BLEZ: cond_met = (a_s <= 0);
            BR_BGTZ: cond_met = (a_s > 0);
            BR_BLTZ: cond_met = (a_s < 0);
            BR_BGEZ: cond_met = (a_s >= 0);
            BR_J:    cond_met = 1'b1;
            default: cond_met = 1'b0;
        endcase
    end

    assign taken          = resolve_en & cond_met;
    assign train_en       = resolve_en & (Branch_Op_ID != BR_RSVD);
    assign PCSrc_ID       = taken;
    assign Mispredict_ID  = train_en & (taken != Pred_Taken_ID);
    assign Flush_IF       = Mispredict_ID;
    assign Redirect_PC_ID = taken ? Target_ID : pc_plus4;

    // Only the word-index bits of the fetch PC address the table.
    assign idx_unused = ^{IF_PC[PC_W-1:IDX_W+2], IF_PC[1:0]};

    branch_bht #(
        .DEPTH (BHT_DEPTH),
        .IDX_W (IDX_W)
    ) u_bht (
        .clk      (clk),
        .reset    (reset),
        .rd_idx   (IF_PC[IDX_W+1:2]),
        .rd_taken (Predict_Taken_IF),
        .wr_en    (train_en),
        .wr_idx   (PC_ID[IDX_W+1:2]),
        .wr_taken (taken)
    );

`ifdef BRANCH_STATS_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            Branch_Count     <= '0;
            Mispredict_Count <= '0;
        end else begin
            if (train_en && Branch_Count != '1)
                Branch_Count <= Branch_Count + 32'd1;
            if (Mispredict_ID && Mispredict_Count != '1)
                Mispredict_Count <= Mispredict_Count + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_id_branch_predict_resolve.sv
// Self-checking bench for id_branch_predict_resolve: directed cases plus
// randomized traffic compared each cycle against a behavioural model.
`timescale 1ns/1ps
module tb_id_branch_predict_resolve;

    localparam int DATA_W = 32;
    localparam int PC_W   = 32;
    localparam int DEPTH  = 64;

    logic              clk = 1'b0;
    logic              reset;
    logic [PC_W-1:0]   IF_PC;
    logic              Predict_Taken_IF;
    logic              Branch_ID;
    logic              Stall_ID;
    logic [2:0]        Branch_Op_ID;
    logic              Pred_Taken_ID;
    logic [PC_W-1:0]   PC_ID;
    logic [PC_W-1:0]   Target_ID;
    logic [DATA_W-1:0] Read_data1_ID;
    logic [DATA_W-1:0] Read_data2_ID;
    logic              PCSrc_ID;
    logic              Mispredict_ID;
    logic [PC_W-1:0]   Redirect_PC_ID;
    logic              Flush_IF;
`ifdef BRANCH_STATS_EN
    logic [31:0]       Branch_Count;
    logic [31:0]       Mispredict_Count;
`endif

    id_branch_predict_resolve #(
        .DATA_W    (DATA_W),
        .PC_W      (PC_W),
        .BHT_DEPTH (DEPTH)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .IF_PC            (IF_PC),
        .Predict_Taken_IF (Predict_Taken_IF),
        .Branch_ID        (Branch_ID),
        .Stall_ID         (Stall_ID),
        .Branch_Op_ID     (Branch_Op_ID),
        .Pred_Taken_ID    (Pred_Taken_ID),
        .PC_ID            (PC_ID),
        .Target_ID        (Target_ID),
        .Read_data1_ID    (Read_data1_ID),
        .Read_data2_ID    (Read_data2_ID),
        .PCSrc_ID         (PCSrc_ID),
        .Mispredict_ID    (Mispredict_ID),
        .Redirect_PC_ID   (Redirect_PC_ID),
        .Flush_IF         (Flush_IF)
`ifdef BRANCH_STATS_EN
        ,
        .Branch_Count     (Branch_Count),
        .Mispredict_Count (Mispredict_Count)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    bit cmp_en   = 1'b0;

    // Behavioural model state: counter value 0..3 per entry, plus stats.
    int          model_bht [DEPTH];
    int unsigned model_br_cnt;
    int unsigned model_mis_cnt;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp)
            n_pass++;
        else
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    function automatic bit ref_taken(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            3'd0:    return a == b;
            3'd1:    return a != b;
            3'd2:    return $signed(a) <= 0;
            3'd3:    return $signed(a) > 0;
            3'd4:    return $signed(a) < 0;
            3'd5:    return $signed(a) >= 0;
            3'd6:    return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic int idx_of(input logic [31:0] pc);
        return int'((pc >> 2) % DEPTH);
    endfunction

    function automatic int step_ctr(input int c, input bit t);
        if (t) return (c >= 3) ? 3 : c + 1;
        return (c <= 0) ? 0 : c - 1;
    endfunction

    // Model training: mirrors the architectural rule, sampled at the clock edge.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            foreach (model_bht[i]) model_bht[i] <= 1;
            model_br_cnt  <= 0;
            model_mis_cnt <= 0;
        end else if (Branch_ID && !Stall_ID && Branch_Op_ID != 3'd7) begin
            model_bht[idx_of(PC_ID)] <= step_ctr(model_bht[idx_of(PC_ID)],
                                                 ref_taken(Branch_Op_ID, Read_data1_ID, Read_data2_ID));
            if (model_br_cnt != 32'hFFFFFFFF) model_br_cnt <= model_br_cnt + 1;
            if (ref_taken(Branch_Op_ID, Read_data1_ID, Read_data2_ID) != Pred_Taken_ID &&
                model_mis_cnt != 32'hFFFFFFFF)
                model_mis_cnt <= model_mis_cnt + 1;
        end
    end

    task automatic compare_outputs();
        bit          en;
        bit          t;
        bit          m;
        logic [31:0] redir;
        en    = Branch_ID && !Stall_ID;
        t     = en && ref_taken(Branch_Op_ID, Read_data1_ID, Read_data2_ID);
        m     = en && Branch_Op_ID != 3'd7 && (t != Pred_Taken_ID);
        redir = t ? Target_ID : PC_ID + 32'd4;
        check("cmp_predict", 64'(Predict_Taken_IF), 64'(model_bht[idx_of(IF_PC)] >= 2));
        check("cmp_pcsrc",   64'(PCSrc_ID),         64'(t));
        check("cmp_mispred", 64'(Mispredict_ID),    64'(m));
        check("cmp_flush",   64'(Flush_IF),         64'(m));
        check("cmp_redirect", 64'(Redirect_PC_ID),  64'(redir));
`ifdef BRANCH_STATS_EN
        check("cmp_br_count",  64'(Branch_Count),     64'(model_br_cnt));
        check("cmp_mis_count", 64'(Mispredict_Count), 64'(model_mis_cnt));
`endif
    endtask

    always @(negedge clk) if (cmp_en) compare_outputs();

    task automatic drive(input bit br, input bit st, input logic [2:0] op, input bit pt,
                         input logic [31:0] pc, input logic [31:0] tgt,
                         input logic [31:0] a, input logic [31:0] b, input logic [31:0] ifpc);
        @(posedge clk);
        #1;
        Branch_ID     = br;
        Stall_ID      = st;
        Branch_Op_ID  = op;
        Pred_Taken_ID = pt;
        PC_ID         = pc;
        Target_ID     = tgt;
        Read_data1_ID = a;
        Read_data2_ID = b;
        IF_PC         = ifpc;
    endtask

    localparam logic [31:0] PC_A  = 32'h0040_0010;
    localparam logic [31:0] TGT_A = 32'h0040_0040;
    localparam logic [31:0] PC_S  = 32'h0040_0080;

    bit          exp_zero [4][3] = '{'{1, 1, 0}, '{0, 0, 1}, '{0, 1, 0}, '{1, 0, 1}};
    logic [31:0] zero_vals [3]   = '{32'h0000_0000, 32'hFFFF_FFFF, 32'h0000_0001};

    initial begin
        reset = 1'b1;
        Branch_ID = 0; Stall_ID = 0; Branch_Op_ID = 0; Pred_Taken_ID = 0;
        PC_ID = 0; Target_ID = 0; Read_data1_ID = 0; Read_data2_ID = 0;
        IF_PC = 32'h0040_0000;
        cmp_en = 1'b1;
        repeat (2) @(posedge clk);
        #2 reset = 1'b0;

        // Reset state and full lookup sweep.
        drive(0, 0, 3'd0, 0, 32'h0, 32'h0, 0, 0, 32'h0040_0000);
        #2 check("reset_predict", 64'(Predict_Taken_IF), 64'd0);
        check("idle_redirect", 64'(Redirect_PC_ID), 64'h4);
        for (int i = 0; i < DEPTH; i++) begin
            drive(0, 0, 3'd0, 0, 32'h0, 32'h0, 0, 0, 32'h0040_0000 + 32'(i * 4));
            #2 check("sweep_predict", 64'(Predict_Taken_IF), 64'd0);
        end

        // BEQ taken against a not-taken prediction; same-index lookup sees old value.
        drive(1, 0, 3'd0, 0, PC_A, TGT_A, 5, 5, PC_A);
        #2;
        check("beq_pcsrc",    64'(PCSrc_ID),       64'd1);
        check("beq_mispred",  64'(Mispredict_ID),  64'd1);
        check("beq_flush",    64'(Flush_IF),       64'd1);
        check("beq_redirect", 64'(Redirect_PC_ID), 64'(TGT_A));
        check("same_idx_old", 64'(Predict_Taken_IF), 64'd0);
        drive(0, 0, 3'd0, 0, 32'h0, 32'h0, 0, 0, PC_A);
        #2 check("beq_trained", 64'(Predict_Taken_IF), 64'd1);

        // Three more taken (saturate at 11), then two not-taken: 11 -> 10 -> 01.
        repeat (3) begin
            drive(1, 0, 3'd0, 1, PC_A, TGT_A, 5, 5, PC_A);
            #2 check("beq_hit_nomis", 64'(Mispredict_ID), 64'd0);
        end
        drive(1, 0, 3'd1, 1, PC_A, TGT_A, 5, 5, PC_A);
        #2;
        check("bne_nt_pcsrc",    64'(PCSrc_ID),       64'd0);
        check("bne_nt_mispred",  64'(Mispredict_ID),  64'd1);
        check("bne_nt_redirect", 64'(Redirect_PC_ID), 64'h0040_0014);
        drive(0, 0, 3'd0, 0, 32'h0, 32'h0, 0, 0, PC_A);
        #2 check("sat_then_wt", 64'(Predict_Taken_IF), 64'd1);
        drive(1, 0, 3'd1, 1, PC_A, TGT_A, 5, 5, PC_A);
        drive(0, 0, 3'd0, 0, 32'h0, 32'h0, 0, 0, PC_A);
        #2 check("down_to_wnt", 64'(Predict_Taken_IF), 64'd0);

        // Signed zero compares.
        for (int op = 0; op < 4; op++) begin
            for (int k = 0; k < 3; k++) begin
                drive(1, 0, 3'(op + 2), 0, 32'h0040_0200 + 32'(op * 16), 32'h0000_1000,
                      zero_vals[k], 32'h1234_5678, 32'h0040_0000);
                #2;
                check("zero_pcsrc", 64'(PCSrc_ID), 64'(exp_zero[op][k]));
                check("zero_redirect", 64'(Redirect_PC_ID),
                      exp_zero[op][k] ? 64'h1000 : 64'(32'h0040_0204 + 32'(op * 16)));
            end
        end

        // Stalled branch: no outputs, no training.
        repeat (2) begin
            drive(1, 1, 3'd0, 0, PC_S, TGT_A, 7, 7, PC_S);
            #2;
            check("stall_pcsrc",    64'(PCSrc_ID),       64'd0);
            check("stall_mispred",  64'(Mispredict_ID),  64'd0);
            check("stall_flush",    64'(Flush_IF),       64'd0);
            check("stall_redirect", 64'(Redirect_PC_ID), 64'h0040_0084);
        end
        drive(0, 0, 3'd0, 0, 32'h0, 32'h0, 0, 0, PC_S);
        #2 check("stall_no_train", 64'(Predict_Taken_IF), 64'd0);

        // J trains like taken; reserved op neither resolves nor trains.
        drive(1, 0, 3'd6, 0, PC_A, TGT_A, 0, 0, PC_A);
        #2 check("j_pcsrc", 64'(PCSrc_ID), 64'd1);
        drive(1, 0, 3'd7, 1, PC_A, TGT_A, 5, 5, PC_A);
        #2;
        check("rsvd_pcsrc",    64'(PCSrc_ID),       64'd0);
        check("rsvd_mispred",  64'(Mispredict_ID),  64'd0);
        check("rsvd_redirect", 64'(Redirect_PC_ID), 64'h0040_0014);
        drive(0, 0, 3'd0, 0, 32'h0, 32'h0, 0, 0, PC_A);
        #2 check("rsvd_no_train", 64'(Predict_Taken_IF), 64'd1);

        // PC+4 wraps.
        drive(1, 0, 3'd1, 0, 32'hFFFF_FFFC, 32'h0000_1000, 3, 3, PC_A);
        #2 check("wrap_redirect", 64'(Redirect_PC_ID), 64'h0);

        // Asynchronous reset in the middle of a stalled branch.
        drive(1, 1, 3'd0, 0, PC_A, TGT_A, 5, 5, PC_A);
        #1 reset = 1'b1;
        #1 check("midreset_predict", 64'(Predict_Taken_IF), 64'd0);
`ifdef BRANCH_STATS_EN
        check("midreset_br_cnt",  64'(Branch_Count),     64'd0);
        check("midreset_mis_cnt", 64'(Mispredict_Count), 64'd0);
`endif
        @(posedge clk);
        #2 reset = 1'b0;

        // Randomized traffic against the model.
        for (int n = 0; n < 600; n++) begin
            logic [31:0] pc;
            logic [31:0] a;
            logic [31:0] b;
            pc = ($urandom_range(0, 19) == 0) ? 32'hFFFF_FFFC
                                              : 32'h0040_0000 + 32'($urandom_range(0, 15) * 4);
            case ($urandom_range(0, 3))
                0:       a = 32'h0;
                1:       a = 32'hFFFF_FFFF;
                2:       a = 32'h1;
                default: a = $urandom;
            endcase
            b = ($urandom_range(0, 1) == 1) ? a : $urandom;
            drive($urandom_range(0, 3) != 0, $urandom_range(0, 4) == 0, 3'($urandom_range(0, 7)),
                  1'($urandom_range(0, 1)), pc, $urandom, a, b,
                  ($urandom_range(0, 1) == 1) ? pc : 32'h0040_0000 + 32'($urandom_range(0, 15) * 4));
            if (n == 300) begin
                #2 reset = 1'b1;
                @(posedge clk);
                #2 reset = 1'b0;
            end
        end

        @(posedge clk);
        #1 cmp_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
